jpeg_data_to_spi: RTL and testbench
===================================

JPEG_DATA_TO_SPI -- requirements
Module: jpeg_data_to_spi

Interface
REQ-001 Parameter HDR_LEN, default 623: number of JPEG header bytes, range 1..1024.
REQ-002 clk  in  1  single clock; all logic on its rising edge.
REQ-003 reset_n  in  1  reset; asynchronous assertion, active-low.
REQ-004 je_done  in  1  encoder-finished level; its rising edge starts a new stream.
REQ-005 jpeg_size  in  17  JPEG body byte count, stable when je_done rises.
REQ-006 hd_addr  out  10  header memory read address.
REQ-007 hd_data  in  8  header memory data, valid one clk after hd_addr.
REQ-008 je_addr  out  17  body memory read address.
REQ-009 je_data  in  8  body memory data, valid one clk after je_addr.
REQ-010 spi_rd  in  1  one-clk pulse from the SPI slave: current byte consumed, advance.
REQ-011 spi_data  out  8  current stream byte, registered.

Function
REQ-012 The stream SHALL be, in order:
- 3 length bytes, big-endian, value TOTAL = HDR_LEN + latched jpeg_size (zero-extended to 24 bits);
- HDR_LEN header bytes, header addresses 0..HDR_LEN-1;
- jpeg_size body bytes, body addresses 0..jpeg_size-1;
- 0x00 padding, indefinitely.
REQ-013 The state machine SHALL have states IDLE, LEN, HDR, BODY, PAD, plus a byte index register (17 bits).
REQ-014 A je_done rising edge (registered edge detect) SHALL latch jpeg_size, set state LEN, index 0, and load spi_data with TOTAL[23:16] on the same clk edge that detects the rise.
REQ-015 je_done rising in any state, including mid-stream, SHALL restart the stream per REQ-014 and cancel any pending fetch; the restart SHALL win over a simultaneous spi_rd.
REQ-016 In IDLE, spi_data SHALL be 0x00 and spi_rd SHALL be ignored.
REQ-017 Advance rule: spi_rd sampled high at edge t SHALL advance index/state at edge t+1.
- LEN bytes 1 and 2 (TOTAL[15:8], TOTAL[7:0]) SHALL load spi_data at edge t+1.
- Leaving LEN after byte 2 SHALL enter HDR, index 0.
- HDR index HDR_LEN-1 -> BODY index 0, or -> PAD if jpeg_size = 0.
- BODY index jpeg_size-1 -> PAD.
REQ-018 Memory fetch pipeline for HDR/BODY bytes:
- hd_addr or je_addr registered to the new index at edge t+1;
- memory data returned at edge t+2;
- spi_data loaded from hd_data or je_data at edge t+3.
REQ-019 spi_data SHALL hold the previous byte until the update edge.
REQ-020 spi_rd asserted while a fetch is pending (edges t+1..t+2) SHALL be ignored; the SPI slave guarantees at least 4 clks between pulses.
REQ-021 In PAD, spi_data SHALL be 0x00 at edge t+1 after the transition, and further spi_rd SHALL be ignored.
REQ-022 hd_addr and je_addr SHALL hold their last value when not fetching; no other outputs exist.
REQ-023 The index SHALL be 17 bits wide; the hd_addr value SHALL be index[9:0]. Terminal comparisons SHALL be equality against HDR_LEN-1 and latched jpeg_size-1, never wrap.
REQ-024 je_done remaining high SHALL NOT retrigger a restart; only a 0->1 transition restarts.

Reset
REQ-025 While reset_n = 0, the block SHALL force:
- state IDLE;
- index 0;
- latched size 0;
- hd_addr = 0, je_addr = 0;
- spi_data = 0x00;
- edge-detect register 0.
REQ-026 After reset release, the block SHALL wait for a je_done rising edge; a je_done already high at release SHALL count as a rise on the first clk.

Verification
REQ-027 HDR_LEN = 4, header memory = 11 22 33 44, jpeg_size = 3, body memory = AA BB CC; pulse je_done, then 10 spi_rd pulses 5 clks apart -> spi_data sequence 00 00 07 11 22 33 44 AA BB CC 00.
REQ-028 jpeg_size = 0, HDR_LEN = 4 -> length bytes 00 00 04, header bytes, then 00 padding; je_addr never changes.
REQ-029 Cycle timing: spi_rd at edge t in HDR -> hd_addr changes at t+1, spi_data changes exactly at t+3 and not earlier.
REQ-030 Restart: je_done re-rises while in BODY with jpeg_size = 0x1FFFF, HDR_LEN = 623 -> spi_data = 0x02 at once; the next two reads give 0x02 then 0x6E (TOTAL = 0x2026E).
REQ-031 Reset asserted mid-BODY -> spi_data = 0x00 and addresses = 0 immediately; spi_rd pulses with no new je_done keep spi_data = 0x00.
REQ-032 spi_rd pulses 1 clk apart -> the second pulse is ignored; the stream advances by one byte only.

Source files
------------

// File: rtl/jpeg_data_to_spi.sv
// Streams a 3-byte big-endian length, the JPEG header and the JPEG body to an
// SPI slave, one byte per spi_rd pulse, then pads with 0x00 until restarted.
module jpeg_data_to_spi #(
  parameter int HDR_LEN = 623
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        je_done,
  input  logic [16:0] jpeg_size,
  output logic [9:0]  hd_addr,
  input  logic [7:0]  hd_data,
  output logic [16:0] je_addr,
  input  logic [7:0]  je_data,
  input  logic        spi_rd,
  output logic [7:0]  spi_data
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_HDR  = 3'd2,
    S_BODY = 3'd3,
    S_PAD  = 3'd4
  } state_t;

  localparam logic [16:0] HDR_LAST  = 17'(HDR_LEN - 1);
  localparam logic [23:0] HDR_LEN24 = 24'(HDR_LEN);

  state_t      r_state;
  logic [16:0] r_idx;
  logic [16:0] r_size;
  logic [9:0]  r_hd_addr;
  logic [16:0] r_je_addr;
  logic [7:0]  r_spi_data;
  logic        r_done_d;
  logic        r_rd;
  logic        r_fetch1;
  logic        r_fetch2;
  logic        r_src_body;

  logic        w_rise;
  logic        w_accept;
  logic        w_streaming;
  logic [16:0] w_idx_inc;
  logic [23:0] w_total_new;
  logic [23:0] w_total;

  assign w_rise      = je_done & ~r_done_d;
  assign w_streaming = (r_state == S_LEN) || (r_state == S_HDR) || (r_state == S_BODY);
  // A pulse is taken only when no advance or fetch is already in flight.
  assign w_accept    = spi_rd & w_streaming & ~r_rd & ~r_fetch1;
  assign w_idx_inc   = r_idx + 17'd1;
  assign w_total_new = HDR_LEN24 + {7'd0, jpeg_size};
  assign w_total     = HDR_LEN24 + {7'd0, r_size};

  assign hd_addr  = r_hd_addr;
  assign je_addr  = r_je_addr;
  assign spi_data = r_spi_data;

  // Stream state machine with its fetch pipeline and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_idx      <= 17'd0;
      r_size     <= 17'd0;
      r_hd_addr  <= 10'd0;
      r_je_addr  <= 17'd0;
      r_spi_data <= 8'h00;
      r_done_d   <= 1'b0;
      r_rd       <= 1'b0;
      r_fetch1   <= 1'b0;
      r_fetch2   <= 1'b0;
      r_src_body <= 1'b0;
    end else begin
      r_done_d <= je_done;
      if (w_rise) begin
        r_size     <= jpeg_size;
        r_state    <= S_LEN;
        r_idx      <= 17'd0;
        r_spi_data <= w_total_new[23:16];
        r_rd       <= 1'b0;
        r_fetch1   <= 1'b0;
        r_fetch2   <= 1'b0;
      end else begin
        r_rd     <= w_accept;
        r_fetch1 <= 1'b0;
        r_fetch2 <= r_fetch1;
        if (r_fetch2) begin
          r_spi_data <= r_src_body ? je_data : hd_data;
        end
        if (r_rd) begin
          case (r_state)
            S_LEN: begin
              if (r_idx == 17'd2) begin
                r_state    <= S_HDR;
                r_idx      <= 17'd0;
                r_hd_addr  <= 10'd0;
                r_src_body <= 1'b0;
                r_fetch1   <= 1'b1;
              end else begin
                r_idx      <= w_idx_inc;
                r_spi_data <= (r_idx == 17'd0) ? w_total[15:8] : w_total[7:0];
              end
            end
            S_HDR: begin
              if (r_idx == HDR_LAST) begin
                if (r_size == 17'd0) begin
                  r_state    <= S_PAD;
                  r_spi_data <= 8'h00;
                end else begin
                  r_state    <= S_BODY;
                  r_idx      <= 17'd0;
                  r_je_addr  <= 17'd0;
                  r_src_body <= 1'b1;
                  r_fetch1   <= 1'b1;
                end
              end else begin
                r_idx     <= w_idx_inc;
                r_hd_addr <= w_idx_inc[9:0];
                r_fetch1  <= 1'b1;
              end
            end
            S_BODY: begin
              if (r_idx == (r_size - 17'd1)) begin
                r_state    <= S_PAD;
                r_spi_data <= 8'h00;
              end else begin
                r_idx     <= w_idx_inc;
                r_je_addr <= w_idx_inc;
                r_fetch1  <= 1'b1;
              end
            end
            default: begin
              r_state <= r_state;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_jpeg_data_to_spi.sv
// Scoreboard bench: a small-header instance for function/timing/restart/reset
// cases and a default-header instance for the full-size restart case.
module tb_jpeg_data_to_spi;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        je_done, je_done2;
  logic [16:0] jpeg_size, jpeg_size2;
  logic [9:0]  hd_addr, hd_addr2;
  logic [7:0]  hd_data, hd_data2;
  logic [16:0] je_addr, je_addr2;
  logic [7:0]  je_data, je_data2;
  logic        spi_rd, spi_rd2;
  logic [7:0]  spi_data, spi_data2;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  jpeg_data_to_spi #(.HDR_LEN(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .je_done(je_done), .jpeg_size(jpeg_size),
    .hd_addr(hd_addr), .hd_data(hd_data), .je_addr(je_addr), .je_data(je_data),
    .spi_rd(spi_rd), .spi_data(spi_data)
  );

  jpeg_data_to_spi #(.HDR_LEN(623)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .je_done(je_done2), .jpeg_size(jpeg_size2),
    .hd_addr(hd_addr2), .hd_data(hd_data2), .je_addr(je_addr2), .je_data(je_data2),
    .spi_rd(spi_rd2), .spi_data(spi_data2)
  );

  function automatic logic [7:0] hmem(input bit w, input int a);
    if (w) return 8'(a) ^ 8'hA5;
    case (a)
      0: return 8'h11;
      1: return 8'h22;
      2: return 8'h33;
      3: return 8'h44;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] bmem(input bit w, input int a);
    if (w) return 8'(a) + 8'h01;
    case (a)
      0: return 8'hAA;
      1: return 8'hBB;
      2: return 8'hCC;
      default: return 8'(a) ^ 8'h3C;
    endcase
  endfunction

  // Reference stream: length, header, body, then zero padding.
  function automatic logic [7:0] exp_byte(input bit w, input int p, input int sz);
    int hl;
    logic [23:0] tot;
    hl  = w ? 623 : 4;
    tot = 24'(hl + sz);
    if (p == 0) return tot[23:16];
    if (p == 1) return tot[15:8];
    if (p == 2) return tot[7:0];
    if (p < 3 + hl) return hmem(w, p - 3);
    if (p < 3 + hl + sz) return bmem(w, p - 3 - hl);
    return 8'h00;
  endfunction

  always @(posedge clk) begin
    hd_data  <= hmem(1'b0, int'(hd_addr));
    je_data  <= bmem(1'b0, int'(je_addr));
    hd_data2 <= hmem(1'b1, int'(hd_addr2));
    je_data2 <= bmem(1'b1, int'(je_addr2));
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_rd(input bit w, input logic v);
    if (w) spi_rd2 = v;
    else   spi_rd  = v;
  endtask

  function automatic logic [7:0] out_data(input bit w);
    return w ? spi_data2 : spi_data;
  endfunction

  task automatic start(input bit w, input logic [16:0] sz, input string tag);
    @(negedge clk);
    if (w) begin jpeg_size2 = sz; je_done2 = 1'b1; end
    else   begin jpeg_size  = sz; je_done  = 1'b1; end
    sb.push_back(exp_byte(w, 0, int'(sz)));
    @(negedge clk);
    check_val(tag, out_data(w), sb.pop_front());
  endtask

  task automatic stop(input bit w);
    @(negedge clk);
    if (w) je_done2 = 1'b0;
    else   je_done  = 1'b0;
    @(negedge clk);
  endtask

  task automatic rd_byte(input bit w, input logic [7:0] exp, input string tag);
    sb.push_back(exp);
    @(negedge clk) set_rd(w, 1'b1);
    @(negedge clk) set_rd(w, 1'b0);
    repeat (3) @(negedge clk);
    check_val(tag, out_data(w), sb.pop_front());
  endtask

  initial begin
    reset_n = 1'b0; je_done = 1'b0; je_done2 = 1'b0; spi_rd = 1'b0; spi_rd2 = 1'b0;
    jpeg_size = 17'd0; jpeg_size2 = 17'd0;
    repeat (3) @(negedge clk);
    check_val("rst_data", spi_data, 8'h00);
    check_val("rst_hd_addr", hd_addr, 10'd0);
    check_val("rst_je_addr", je_addr, 17'd0);
    reset_n = 1'b1;
    @(negedge clk);
    rd_byte(1'b0, 8'h00, "idle_rd");

    // Basic stream, with one header read checked cycle by cycle.
    start(1'b0, 17'd3, "len0");
    for (int p = 1; p <= 10; p++) begin
      if (p == 4) begin
        sb.push_back(exp_byte(1'b0, 4, 3));
        @(negedge clk) spi_rd = 1'b1;
        @(negedge clk) spi_rd = 1'b0;
        check_val("t0_addr", hd_addr, 10'd0);
        @(negedge clk);
        check_val("t1_addr", hd_addr, 10'd1);
        check_val("t1_hold", spi_data, 8'h11);
        @(negedge clk);
        check_val("t2_hold", spi_data, 8'h11);
        @(negedge clk);
        check_val("t3_data", spi_data, sb.pop_front());
      end else begin
        rd_byte(1'b0, exp_byte(1'b0, p, 3), "seq");
      end
    end
    stop(1'b0);

    // Empty body: header goes straight to padding, body address untouched.
    start(1'b0, 17'd0, "len0_empty");
    for (int p = 1; p <= 9; p++) begin
      rd_byte(1'b0, exp_byte(1'b0, p, 0), "empty_seq");
      check_val("empty_je_addr", je_addr, 17'd2);
    end
    stop(1'b0);

    // Back-to-back pulses advance only one byte.
    start(1'b0, 17'd3, "len0_dbl");
    for (int p = 1; p <= 3; p++) rd_byte(1'b0, exp_byte(1'b0, p, 3), "dbl_pre");
    sb.push_back(exp_byte(1'b0, 4, 3));
    @(negedge clk) spi_rd = 1'b1;
    @(negedge clk);
    @(negedge clk) spi_rd = 1'b0;
    repeat (3) @(negedge clk);
    check_val("dbl_one", spi_data, sb.pop_front());
    for (int p = 5; p <= 7; p++) rd_byte(1'b0, exp_byte(1'b0, p, 3), "dbl_post");

    // Restart mid-body with a simultaneous spi_rd: restart wins.
    @(negedge clk) je_done = 1'b0;
    @(negedge clk);
    @(negedge clk) begin je_done = 1'b1; jpeg_size = 17'h10000; spi_rd = 1'b1; end
    sb.push_back(exp_byte(1'b0, 0, 'h10000));
    @(negedge clk) spi_rd = 1'b0;
    check_val("restart", spi_data, sb.pop_front());
    repeat (4) @(negedge clk);
    check_val("restart_rd_ign", spi_data, exp_byte(1'b0, 0, 'h10000));
    for (int p = 1; p <= 8; p++) rd_byte(1'b0, exp_byte(1'b0, p, 'h10000), "restart_seq");

    // Asynchronous reset mid-body.
    @(negedge clk) je_done = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check_val("arst_data", spi_data, 8'h00);
    check_val("arst_hd_addr", hd_addr, 10'd0);
    check_val("arst_je_addr", je_addr, 17'd0);
    @(negedge clk);
    @(negedge clk) reset_n = 1'b1;
    rd_byte(1'b0, 8'h00, "post_rst_idle");
    rd_byte(1'b0, 8'h00, "post_rst_idle");

    // je_done already high at reset release counts as a rise.
    @(negedge clk) begin reset_n = 1'b0; jpeg_size = 17'h1FFFF; je_done = 1'b1; end
    @(negedge clk) reset_n = 1'b1;
    sb.push_back(exp_byte(1'b0, 0, 'h1FFFF));
    @(negedge clk);
    check_val("rel_high", spi_data, sb.pop_front());
    rd_byte(1'b0, exp_byte(1'b0, 1, 'h1FFFF), "rel_seq");
    rd_byte(1'b0, exp_byte(1'b0, 2, 'h1FFFF), "rel_seq");
    stop(1'b0);

    // Full-size header: run into the body, then restart.
    start(1'b1, 17'h1FFFF, "big_len0");
    for (int p = 1; p <= 3 + 623 + 2; p++) rd_byte(1'b1, exp_byte(1'b1, p, 'h1FFFF), "big_seq");
    stop(1'b1);
    start(1'b1, 17'h1FFFF, "big_restart");
    rd_byte(1'b1, 8'h02, "big_len1");
    rd_byte(1'b1, 8'h6E, "big_len2");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
